// File: rtl/dave_damage_ctrl.sv
// Hit sequencer for Dave: turns hazard overlap into one life-loss pulse, then
// runs the frame-timed death animation, respawn pulse and blinking shield window.
module dave_damage_ctrl #(
    parameter int unsigned DEATH_FRAMES  = 60,
    parameter int unsigned SHIELD_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES  = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       hazardCollision,
    input  logic       godMode,
    input  logic [3:0] remainingLives,
    output logic       decreaseLife,
    output logic       immortal,
    output logic       respawn,
    output logic       daveDying,
    output logic       daveVisible,
    output logic       gameOver
);

    localparam logic [7:0] LP_DEATH  = 8'(DEATH_FRAMES);
    localparam logic [7:0] LP_SHIELD = 8'(SHIELD_FRAMES);
    localparam logic [7:0] LP_BLINK  = 8'(BLINK_FRAMES);

    typedef enum logic [2:0] {
        ST_ALIVE,
        ST_DYING,
        ST_RESPAWN,
        ST_SHIELDED,
        ST_GAMEOVER
    } state_t;

    state_t     r_state,     w_state;
    logic [7:0] r_frame_cnt, w_frame_cnt;
    logic [7:0] r_blink_cnt, w_blink_cnt;
    logic       r_decrease,  w_decrease;
    logic       r_respawn,   w_respawn;
    logic       r_dying,     w_dying;
    logic       r_visible,   w_visible;
    logic       r_game_over, w_game_over;
    logic       r_immortal,  w_immortal;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= ST_ALIVE;
            r_frame_cnt <= '0;
            r_blink_cnt <= '0;
            r_decrease  <= 1'b0;
            r_respawn   <= 1'b0;
            r_dying     <= 1'b0;
            r_visible   <= 1'b1;
            r_game_over <= 1'b0;
            r_immortal  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_frame_cnt <= w_frame_cnt;
            r_blink_cnt <= w_blink_cnt;
            r_decrease  <= w_decrease;
            r_respawn   <= w_respawn;
            r_dying     <= w_dying;
            r_visible   <= w_visible;
            r_game_over <= w_game_over;
            r_immortal  <= w_immortal;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_frame_cnt = r_frame_cnt;
        w_blink_cnt = r_blink_cnt;
        w_decrease  = 1'b0;
        w_respawn   = 1'b0;
        w_dying     = r_dying;
        w_visible   = r_visible;
        w_game_over = r_game_over;
        w_immortal  = r_immortal;

        unique case (r_state)
            ST_ALIVE: begin
                w_dying    = 1'b0;
                w_visible  = 1'b1;
                w_immortal = 1'b0;
                // Registered immortal term stays low on the first DYING cycle so the
                // lives FSM accepts exactly this one decrement.
                if (hazardCollision && !godMode) begin
                    w_state     = ST_DYING;
                    w_frame_cnt = LP_DEATH;
                    w_decrease  = 1'b1;
                    w_dying     = 1'b1;
                end
            end
            ST_DYING: begin
                w_immortal = 1'b1;
                w_dying    = 1'b1;
                w_visible  = 1'b1;
                if (startOfFrame) begin
                    w_frame_cnt = r_frame_cnt - 8'd1;
                    if (r_frame_cnt == 8'd1) begin
                        w_dying = 1'b0;
                        if (remainingLives == 4'd0) begin
                            w_state     = ST_GAMEOVER;
                            w_game_over = 1'b1;
                            w_visible   = 1'b0;
                        end else begin
                            w_state   = ST_RESPAWN;
                            w_respawn = 1'b1;
                        end
                    end
                end
            end
            ST_RESPAWN: begin
                w_state     = ST_SHIELDED;
                w_frame_cnt = LP_SHIELD;
                w_blink_cnt = LP_BLINK;
                w_visible   = 1'b1;
                w_immortal  = 1'b1;
            end
            ST_SHIELDED: begin
                w_immortal = 1'b1;
                if (startOfFrame) begin
                    w_frame_cnt = r_frame_cnt - 8'd1;
                    if (r_blink_cnt == 8'd1) begin
                        w_visible   = ~r_visible;
                        w_blink_cnt = LP_BLINK;
                    end else begin
                        w_blink_cnt = r_blink_cnt - 8'd1;
                    end
                    if (r_frame_cnt == 8'd1) begin
                        w_state    = ST_ALIVE;
                        w_visible  = 1'b1;
                        w_immortal = 1'b0;
                    end
                end
            end
            ST_GAMEOVER: begin
                w_game_over = 1'b1;
                w_immortal  = 1'b1;
                w_visible   = 1'b0;
                w_dying     = 1'b0;
            end
            default: begin
                w_state = ST_ALIVE;
            end
        endcase
    end

    assign decreaseLife = r_decrease;
    assign respawn      = r_respawn;
    assign daveDying    = r_dying;
    assign daveVisible  = r_visible;
    assign gameOver     = r_game_over;
    assign immortal     = r_immortal | godMode;

endmodule

// File: tb/tb_dave_damage_ctrl.sv
module tb_dave_damage_ctrl;

  localparam int DEATH  = 3;
  localparam int SHIELD = 4;
  localparam int BLINK  = 2;

  logic       clk             = 1'b0;
  logic       resetN          = 1'b0;
  logic       startOfFrame    = 1'b0;
  logic       hazardCollision = 1'b0;
  logic       godMode         = 1'b0;
  logic [3:0] remainingLives  = 4'd3;
  logic       decreaseLife, immortal, respawn, daveDying, daveVisible, gameOver;

  dave_damage_ctrl #(
    .DEATH_FRAMES (DEATH),
    .SHIELD_FRAMES(SHIELD),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .hazardCollision(hazardCollision),
    .godMode        (godMode),
    .remainingLives (remainingLives),
    .decreaseLife   (decreaseLife),
    .immortal       (immortal),
    .respawn        (respawn),
    .daveDying      (daveDying),
    .daveVisible    (daveVisible),
    .gameOver       (gameOver)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic dec;
    logic resp;
    logic dying;
    logic vis;
    logic go;
    logic imm;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  int   m_phase = 0;
  int   m_ticks = 0;
  logic m_first = 1'b0;

  function void model_reset();
    m_phase = 0;
    m_ticks = 0;
    m_first = 1'b0;
  endfunction

  function void model_edge();
    if (!resetN) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: if (hazardCollision && !godMode) begin
           m_phase = 1;
           m_ticks = 0;
           m_first = 1'b1;
         end
      1: begin
           m_first = 1'b0;
           if (startOfFrame) begin
             m_ticks++;
             if (m_ticks == DEATH) begin
               m_phase = (remainingLives == 4'd0) ? 4 : 2;
               m_ticks = 0;
             end
           end
         end
      2: begin
           m_phase = 3;
           m_ticks = 0;
         end
      3: if (startOfFrame) begin
           m_ticks++;
           if (m_ticks == SHIELD) begin
             m_phase = 0;
             m_ticks = 0;
           end
         end
      default: ;
    endcase
  endfunction

  function obs_t model_out();
    obs_t o;
    o = '0;
    case (m_phase)
      0: begin o.vis = 1'b1; o.imm = godMode; end
      1: begin
           o.dec   = m_first;
           o.dying = 1'b1;
           o.vis   = 1'b1;
           o.imm   = m_first ? godMode : 1'b1;
         end
      2: begin o.resp = 1'b1; o.vis = 1'b1; o.imm = 1'b1; end
      3: begin o.vis = ((m_ticks / BLINK) % 2) == 0; o.imm = 1'b1; end
      default: begin o.go = 1'b1; o.imm = 1'b1; end
    endcase
    return o;
  endfunction

  task automatic cycle(input logic hz, input logic gm, input logic sof, input logic rstn,
                       input logic [3:0] lv);
    @(posedge clk);
    model_edge();
    #1;
    hazardCollision = hz;
    godMode         = gm;
    startOfFrame    = sof;
    remainingLives  = lv;
    resetN          = rstn;
    if (!rstn) model_reset();
    sb.push_back(model_out());
  endtask

  task automatic run(input int unsigned n, input logic hz, input logic gm, input logic [3:0] lv);
    for (int unsigned i = 0; i < n; i++)
      cycle(hz, gm, (i % 4) == 3, 1'b1, lv);
  endtask

  task automatic check_reset_state();
    #1;
    n_cmp++;
    if (decreaseLife !== 1'b0 || respawn !== 1'b0 || daveDying !== 1'b0 ||
        daveVisible !== 1'b1 || gameOver !== 1'b0 || immortal !== godMode) begin
      n_bad++;
      $display("FAIL reset state: dec=%b resp=%b dying=%b vis=%b go=%b imm=%b (godMode=%b)",
               decreaseLife, respawn, daveDying, daveVisible, gameOver, immortal, godMode);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {decreaseLife, respawn, daveDying, daveVisible, gameOver, immortal};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got dec=%b resp=%b dying=%b vis=%b go=%b imm=%b, expected dec=%b resp=%b dying=%b vis=%b go=%b imm=%b",
                 cyc, a.dec, a.resp, a.dying, a.vis, a.go, a.imm,
                 e.dec, e.resp, e.dying, e.vis, e.go, e.imm);
      end
    end
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL timeout: stimulus did not complete within the wait budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic gm_r;
    cycle(0, 0, 0, 0, 3);
    check_reset_state();
    cycle(0, 0, 1, 0, 3);
    run(5, 0, 0, 3);

    cycle(1, 0, 0, 1, 3);
    run(40, 0, 0, 3);

    run(70, 1, 0, 3);
    run(40, 0, 0, 3);

    for (int unsigned i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 1, 3);
      cycle(0, 1, 1, 1, 3);
    end
    run(8, 0, 1, 3);

    cycle(1, 0, 1, 1, 3);
    run(10, 0, 1, 3);
    run(30, 0, 0, 3);

    cycle(1, 0, 0, 1, 0);
    run(20, 0, 0, 0);
    run(20, 1, 0, 0);
    run(8, 1, 1, 2);
    cycle(0, 0, 0, 0, 3);
    check_reset_state();
    run(6, 0, 0, 3);

    cycle(1, 0, 0, 1, 3);
    run(6, 0, 0, 3);
    cycle(0, 0, 0, 0, 3);
    check_reset_state();
    run(4, 0, 0, 3);
    cycle(1, 0, 0, 1, 3);
    run(18, 0, 0, 3);
    cycle(0, 0, 0, 0, 3);
    check_reset_state();
    cycle(0, 0, 0, 0, 3);
    run(4, 0, 0, 3);
    cycle(1, 0, 0, 1, 3);
    run(40, 0, 0, 3);

    gm_r = 1'b0;
    for (int unsigned i = 0; i < 3000; i++) begin
      logic [3:0] lv;
      if ($urandom_range(0, 49) == 0) gm_r = ~gm_r;
      lv = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
      cycle($urandom_range(0, 9) == 0, gm_r, $urandom_range(0, 3) == 0,
            $urandom_range(0, 299) != 0, lv);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
